// File: rtl/paint_logo_anim.sv
// Paints a scaled "P" glyph that slides horizontally once per qualifying frame.
// Define LOGO_BOUNCE_EN for ping-pong motion; otherwise the offset wraps rightward.
module paint_logo_anim #(
  parameter int unsigned X0       = 500,
  parameter int unsigned Y0       = 550,
  parameter int unsigned SCALE    = 1,
  parameter int unsigned MAX_DELT = 100,
  parameter int unsigned STEP     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pause,
  input  logic        frame_start,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        hit,
  output logic [10:0] delt
);

  localparam logic [11:0] LP_BX   = 12'(X0 + 10 * SCALE);
  localparam logic [11:0] LP_W5   = 12'(5 * SCALE);
  localparam logic [11:0] LP_W20  = 12'(20 * SCALE);
  localparam logic [11:0] LP_W25  = 12'(25 * SCALE);
  localparam logic [11:0] LP_Y0   = 12'(Y0);
  localparam logic [11:0] LP_Y5   = 12'(Y0 + 5 * SCALE);
  localparam logic [11:0] LP_Y20  = 12'(Y0 + 20 * SCALE);
  localparam logic [11:0] LP_Y25  = 12'(Y0 + 25 * SCALE);
  localparam logic [11:0] LP_Y40  = 12'(Y0 + 40 * SCALE);
  localparam logic [11:0] LP_STEP = 12'(STEP);
  localparam logic [11:0] LP_MAX  = 12'(MAX_DELT);

  logic [10:0] r_delt;
  logic        r_hit;
  logic [11:0] w_x;
  logic [11:0] w_y;
  logic [11:0] w_bx;
  logic [11:0] w_sum;
  logic [10:0] w_delt_nxt;
  logic        w_r1, w_r2, w_r3, w_r4;
  logic        w_in;
  logic        w_adv;

  // All glyph edges are offsets from the stem's left edge w_bx.
  always_comb begin
    w_x  = {1'b0, x};
    w_y  = {1'b0, y};
    w_bx = LP_BX + {1'b0, r_delt};
    w_r1 = (w_x >= w_bx) && (w_x < w_bx + LP_W20) && (w_y >= LP_Y0) && (w_y < LP_Y5);
    w_r2 = (w_x >= w_bx) && (w_x < w_bx + LP_W5)  && (w_y >= LP_Y0) && (w_y < LP_Y40);
    w_r3 = (w_x >= w_bx + LP_W20) && (w_x < w_bx + LP_W25) && (w_y >= LP_Y0) && (w_y < LP_Y20);
    w_r4 = (w_x >= w_bx) && (w_x < w_bx + LP_W20) && (w_y >= LP_Y20) && (w_y < LP_Y25);
    w_in  = w_r1 | w_r2 | w_r3 | w_r4;
    w_adv = frame_start & enable & ~pause;
    w_sum = {1'b0, r_delt} + LP_STEP;
  end

`ifdef LOGO_BOUNCE_EN
  localparam logic [0:0] ST_RIGHT = 1'b0;
  localparam logic [0:0] ST_LEFT  = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_delt_nxt  = r_delt;
    if (r_state == ST_RIGHT) begin
      if (w_sum >= LP_MAX) begin
        w_delt_nxt  = LP_MAX[10:0];
        w_state_nxt = ST_LEFT;
      end else begin
        w_delt_nxt = w_sum[10:0];
      end
    end else begin
      if ({1'b0, r_delt} <= LP_STEP) begin
        w_delt_nxt  = '0;
        w_state_nxt = ST_RIGHT;
      end else begin
        w_delt_nxt = r_delt - LP_STEP[10:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RIGHT;
    end else if (w_adv) begin
      r_state <= w_state_nxt;
    end
  end
`else
  always_comb begin
    w_delt_nxt = '0;
    if (w_sum <= LP_MAX) begin
      w_delt_nxt = w_sum[10:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_delt <= '0;
      r_hit  <= 1'b0;
    end else begin
      r_hit <= enable & w_in;
      if (w_adv) begin
        r_delt <= w_delt_nxt;
      end
    end
  end

  assign hit  = r_hit;
  assign delt = r_delt;

endmodule

// File: tb/tb_paint_logo_anim.sv
// Scoreboard bench for paint_logo_anim: directed scenarios then random traffic,
// checked against a glyph-geometry reference model. Honours LOGO_BOUNCE_EN.
module tb_paint_logo_anim;

  localparam int X0       = 500;
  localparam int Y0       = 550;
  localparam int SCALE    = 1;
  localparam int MAX_DELT = 100;
  localparam int STEP     = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pause = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] x = '0;
  logic [10:0] y = '0;
  logic        hit;
  logic [10:0] delt;

  paint_logo_anim #(
    .X0(X0), .Y0(Y0), .SCALE(SCALE), .MAX_DELT(MAX_DELT), .STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pause(pause),
    .frame_start(frame_start), .x(x), .y(y), .hit(hit), .delt(delt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic [10:0] delt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_delt = 0;
  bit   m_left = 1'b0;

  // Glyph in local coordinates: u measured from the stem's left edge, v from the top.
  function automatic bit on_glyph(int xx, int yy, int d);
    int u, v;
    u = xx - (X0 + d + 10 * SCALE);
    v = yy - Y0;
    if (u < 0 || v < 0) return 1'b0;
    return (u < 20 * SCALE && v < 5 * SCALE) ||
           (u < 5 * SCALE && v < 40 * SCALE) ||
           (u >= 20 * SCALE && u < 25 * SCALE && v < 20 * SCALE) ||
           (u < 20 * SCALE && v >= 20 * SCALE && v < 25 * SCALE);
  endfunction

  task automatic advance_model();
`ifdef LOGO_BOUNCE_EN
    if (!m_left) begin
      if (m_delt + STEP >= MAX_DELT) begin
        m_delt = MAX_DELT;
        m_left = 1'b1;
      end else begin
        m_delt = m_delt + STEP;
      end
    end else if (m_delt <= STEP) begin
      m_delt = 0;
      m_left = 1'b0;
    end else begin
      m_delt = m_delt - STEP;
    end
`else
    m_delt = (m_delt + STEP > MAX_DELT) ? 0 : m_delt + STEP;
`endif
  endtask

  // Drive one cycle at the negative edge, predict the post-edge outputs, and
  // return at the following negative edge.
  task automatic cyc(input bit r, input bit en, input bit pa, input bit fs,
                     input int xx, input int yy);
    exp_t e;
    rst = r; enable = en; pause = pa; frame_start = fs;
    x = 11'(xx); y = 11'(yy);
    if (r) begin
      m_delt = 0;
      m_left = 1'b0;
      e.hit  = 1'b0;
    end else begin
      e.hit = en && on_glyph(xx, yy, m_delt);
      if (fs && en && !pa) advance_model();
    end
    e.delt = 11'(m_delt);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
  endtask

  task automatic check_delt(input int exp, input string nm);
    n_cmp++;
    if (delt !== 11'(exp)) begin
      n_bad++;
      $display("FAIL %s: delt=%0d expected %0d", nm, delt, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (hit !== e.hit || delt !== e.delt) begin
          n_bad++;
          $display("FAIL scoreboard @%0t: hit=%0b delt=%0d expected hit=%0b delt=%0d",
                   $time, hit, delt, e.hit, e.delt);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    check_delt(0, "reset");

    // Static glyph probes at delt=0, including edges.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 510, 550);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 534, 560);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 535, 560);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 512, 574);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 520, 580);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 509, 550);

    pulses(5);
    check_delt(5, "five_pulses");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 515, 550);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 514, 550);

    // Full sweep with frame_start held high across consecutive cycles.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    pulses(100);
    check_delt(100, "pulse100");
    pulses(1);
`ifdef LOGO_BOUNCE_EN
    check_delt(99, "pulse101_bounce");
    pulses(99);
    check_delt(0, "pulse200_bounce");
    pulses(1);
    check_delt(1, "pulse201_bounce");
`else
    check_delt(0, "pulse101_wrap");
`endif

    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 510, 550);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 510, 550);
`ifdef LOGO_BOUNCE_EN
    check_delt(1, "hold_pause_disable");
`else
    check_delt(0, "hold_pause_disable");
`endif

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    pulses(37);
    check_delt(37, "reach37");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 510, 550);
    check_delt(0, "rst_over_frame");
    pulses(1);
    check_delt(1, "after_rst_moves_right");

    for (int i = 0; i < 4000; i++) begin
      bit r, en, pa, fs;
      int xx, yy;
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      pa = ($urandom_range(0, 9) == 0);
      fs = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) begin
        xx = $urandom_range(0, 2047);
        yy = $urandom_range(0, 2047);
      end else begin
        xx = $urandom_range(X0, X0 + MAX_DELT + 40 * SCALE);
        yy = $urandom_range(Y0 - 5, Y0 + 45 * SCALE);
      end
      cyc(r, en, pa, fs, xx, yy);
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
